udma_smi_responder: RTL and testbench
=====================================

Name: udma_smi_responder

Overview:
- Clause-22 SMI/MDIO target (PHY side): oversamples MDC/MDIO on the system clock, decodes management frames and answers reads/writes via a simple register-port handshake.
- Used as an on-chip management target and as the loop-back partner for the uDMA SMI master.
- Frame format: preamble, ST=01, OP (10 read / 01 write), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0]. All fields are MSB first.

Parameters:
- PREAMBLE_MIN, 32, number of consecutive 1 bits required before ST is accepted (1..32).
- SYNC_STAGES, 2, flip-flop stages on the mdc_i and mdio_i synchronisers (>=2).

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  synchronous active-low reset.
- phy_addr_i  in  5  this target's PHY address; static while busy_o=1.
- mdc_i  in  1  management clock from the master (asynchronous).
- mdio_i  in  1  MDIO pad input (asynchronous).
- mdio_o  out  1  MDIO drive value.
- mdio_oe_o  out  1  MDIO output enable.
- reg_addr_o  out  5  register address of the current frame.
- reg_rd_o  out  1  one-cycle read strobe.
- reg_rdata_i  in  16  read data; sampled exactly 1 clk after reg_rd_o.
- reg_we_o  out  1  one-cycle write strobe.
- reg_wdata_o  out  16  write data; valid while reg_we_o=1.
- busy_o  out  1  high from ST detected to end of frame.
- frame_err_o  out  1  one-cycle pulse on a malformed frame addressed to this PHY.

Behaviour:
- Reset values: all outputs 0 (mdio_o=0, mdio_oe_o=0); FSM goes to IDLE; preamble count 0. Reset asserted mid-frame aborts the frame, with no strobes and oe released on the next clk.
- Synchronise mdc_i and mdio_i through SYNC_STAGES FFs, then edge-detect MDC on the synchronised signal.
- A "bit" is the synchronised mdio value at an MDC rising edge. Drive changes occur only on MDC falling edges.
- Timing requirement: each MDC high and low phase must be >= SYNC_STAGES+2 clk.
- IDLE: a 1 increments the preamble count, saturating at 32. A 0 with count >= PREAMBLE_MIN goes to ST, sets busy_o=1 and clears the count. A 0 with count < PREAMBLE_MIN clears the count and stays in IDLE.
- ST: expect 1, then go to OP. On a 0, return to IDLE (not a frame error).
- OP: collect 2 bits. 10 = read, 01 = write, then go to PHYAD. 00 or 11 returns to IDLE with busy_o=0 and no error.
- PHYAD: collect 5 bits, then go to REGAD. A match flag is latched = (PHYAD == phy_addr_i).
- REGAD: collect 5 bits into reg_addr_o.
- Mismatched PHYAD: enter SKIP for 18 further bits, never driving, then go to IDLE.
- Read, REGAD last rising edge:
  - reg_rd_o pulses for 1 clk; reg_rdata_i is latched into the shift register on the next clk.
  - TA bit 1: oe stays 0.
  - Falling edge before TA bit 2: oe=1, mdio_o=0.
  - Next 16 falling edges: drive DATA[15] down to DATA[0].
  - The falling edge after DATA[0]: oe=0, then go to IDLE and busy_o=0.
- Write, TA:
  - Sample 2 bits; 10 goes to DATA.
  - Any other value pulses frame_err_o, goes to IDLE and performs no write.
  - DATA: shift in 16 bits. On the 16th rising edge: reg_wdata_o updated, reg_we_o pulses 1 clk on the following clk, then go to IDLE.
- Preamble counting restarts only in IDLE. A count accrued during a previous frame's bits never counts.
- Simultaneous events: the MDC rising and falling edges cannot occur in the same clk (guaranteed by the timing requirement). A strobe and a reset in the same cycle: reset wins, no strobe.

Optional Feature:
- Macro: SMI_RESP_PREAMBLE_SUPPRESS_EN.
- Defined:
  - After a frame that completed successfully (read or write) addressed to this PHY, a flag allows the next frame's ST to be accepted after >= 1 idle 1 bit, without a full preamble.
  - The flag clears on reset, on any error or abort, or when ST is accepted.
- Undefined: every frame needs PREAMBLE_MIN ones, and the flag logic is absent.

Test Plan:
- phy_addr_i=5'h03, write frame 32x1, 01, 01, 00011, 01010, 10, 16'hBEEF -> one reg_we_o pulse with reg_addr_o=5'h0A and reg_wdata_o=16'hBEEF; oe never asserted.
- Read frame to PHY 3, reg 5'h11, reg_rdata_i=16'h1234 -> reg_rd_o pulses once; TA bit 1 has oe=0; TA bit 2 has mdio_o=0; then data bits 0001_0010_0011_0100 are sampled on rising edges; oe=0 after the last falling edge.
- Read to PHYAD 5'h04 while phy_addr_i=5'h03 -> no strobes, oe stays 0, busy_o falls after 18 skipped bits; an immediate correct frame is then accepted.
- Write with TA=11 -> frame_err_o pulses once, no reg_we_o.
- Preamble of 31 ones then ST (PREAMBLE_MIN=32) -> frame ignored with no strobes; repeat with 32 ones -> accepted.
- rstn_i=0 in the middle of read data -> next clk oe=0, busy_o=0; the following frame decodes normally. With SMI_RESP_PREAMBLE_SUPPRESS_EN: back-to-back read after a good write with 1 idle bit -> accepted.

Source files
------------

// File: rtl/udma_smi_responder.sv
// udma_smi_responder
// Clause-22 SMI/MDIO management target (PHY side). MDC and MDIO are
// oversampled on clk_i; management frames addressed to phy_addr_i are turned
// into single-cycle register-port strobes, and read data is shifted back out
// on MDIO.
//
// Ports
//   clk_i, rstn_i          system clock, synchronous active-low reset
//   phy_addr_i[4:0]        this target's PHY address (static while busy_o)
//   mdc_i, mdio_i          asynchronous management clock / MDIO pad input
//   mdio_o, mdio_oe_o      MDIO drive value and output enable
//   reg_addr_o[4:0]        register address of the current frame
//   reg_rd_o               read strobe; reg_rdata_i[15:0] sampled 1 clk later
//   reg_we_o               write strobe, reg_wdata_o[15:0] valid with it
//   busy_o                 high from ST detected to end of frame
//   frame_err_o            pulse on a write frame to this PHY with bad TA
//
// Build option
//   SMI_RESP_PREAMBLE_SUPPRESS_EN: after a successful frame to this PHY the
//   next ST is accepted after a single idle 1 bit.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | counting preamble ones, waiting for the ST 0 bit
// S_ST      | expecting the second ST bit (1)
// S_OP      | collecting the 2 opcode bits
// S_PHYAD   | collecting PHYAD, match flag latched on the last bit
// S_REGAD   | collecting REGAD into reg_addr_o
// S_SKIP    | frame for another PHY, letting TA + DATA (18 bits) pass
// S_RD_TA   | read turnaround, oe asserted on the 2nd falling edge
// S_RD_DATA | driving DATA[15:0] on falling edges, release after DATA[0]
// S_WR_TA   | sampling write TA, must be 10
// S_WR_DATA | shifting in 16 write data bits

module udma_smi_responder #(
  parameter int unsigned PREAMBLE_MIN = 32,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [4:0]  phy_addr_i,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  output logic [4:0]  reg_addr_o,
  output logic        reg_rd_o,
  input  logic [15:0] reg_rdata_i,
  output logic        reg_we_o,
  output logic [15:0] reg_wdata_o,
  output logic        busy_o,
  output logic        frame_err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_SKIP,
    S_RD_TA, S_RD_DATA, S_WR_TA, S_WR_DATA
  } state_e;

  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);
  localparam logic [5:0] PRE_SAT = 6'd32;

  logic [SYNC_STAGES-1:0] mdc_sync_q, mdio_sync_q;
  logic                   mdc_prev_q;
  logic                   mdc_rise, mdc_fall, bit_in, pre_ok;

  state_e      state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic        is_rd_q, is_rd_d;
  logic        match_q, match_d;
  logic        mdio_q, mdio_d;
  logic        oe_q, oe_d;
  logic        rd_q, rd_d;
  logic        rd_dly_q;
  logic        we_pend_q, we_pend_d;
  logic        we_q;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  assign bit_in   = mdio_sync_q[SYNC_STAGES-1];
  assign mdc_rise =  mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
  assign mdc_fall = ~mdc_sync_q[SYNC_STAGES-1] &  mdc_prev_q;

`ifdef SMI_RESP_PREAMBLE_SUPPRESS_EN
  logic sup_q, sup_d;
  assign pre_ok = (pre_cnt_q >= PRE_MIN) || (sup_q && (pre_cnt_q != 6'd0));
`else
  assign pre_ok = (pre_cnt_q >= PRE_MIN);
`endif

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = (state_q == S_IDLE) ? pre_cnt_q : 6'd0;
    bit_cnt_d  = bit_cnt_q;
    // Read data arrives one clk after the strobe cycle.
    shift_d    = rd_dly_q ? reg_rdata_i : shift_q;
    reg_addr_d = reg_addr_q;
    is_rd_d    = is_rd_q;
    match_d    = match_q;
    mdio_d     = mdio_q;
    oe_d       = oe_q;
    rd_d       = 1'b0;
    we_pend_d  = 1'b0;
    wdata_d    = wdata_q;
    err_d      = 1'b0;
`ifdef SMI_RESP_PREAMBLE_SUPPRESS_EN
    sup_d      = sup_q;
`endif
    case (state_q)
      S_IDLE: if (mdc_rise) begin
        if (bit_in) begin
          if (pre_cnt_q < PRE_SAT) pre_cnt_d = pre_cnt_q + 6'd1;
        end else begin
          pre_cnt_d = 6'd0;
          if (pre_ok) begin
            state_d = S_ST;
`ifdef SMI_RESP_PREAMBLE_SUPPRESS_EN
            sup_d   = 1'b0;
`endif
          end
        end
      end
      S_ST: if (mdc_rise) begin
        bit_cnt_d = 5'd0;
        state_d   = bit_in ? S_OP : S_IDLE;
      end
      S_OP: if (mdc_rise) begin
        shift_d = {shift_q[14:0], bit_in};
        if (bit_cnt_q == 5'd0) begin
          bit_cnt_d = 5'd1;
        end else begin
          bit_cnt_d = 5'd0;
          case ({shift_q[0], bit_in})
            2'b10:   begin is_rd_d = 1'b1; state_d = S_PHYAD; end
            2'b01:   begin is_rd_d = 1'b0; state_d = S_PHYAD; end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_PHYAD: if (mdc_rise) begin
        shift_d = {shift_q[14:0], bit_in};
        if (bit_cnt_q == 5'd4) begin
          match_d   = ({shift_q[3:0], bit_in} == phy_addr_i);
          bit_cnt_d = 5'd0;
          state_d   = S_REGAD;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      S_REGAD: if (mdc_rise) begin
        reg_addr_d = {reg_addr_q[3:0], bit_in};
        if (bit_cnt_q == 5'd4) begin
          bit_cnt_d = 5'd0;
          if (!match_q)     state_d = S_SKIP;
          else if (is_rd_q) begin state_d = S_RD_TA; rd_d = 1'b1; end
          else              state_d = S_WR_TA;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      S_SKIP: if (mdc_rise) begin
        if (bit_cnt_q == 5'd17) state_d = S_IDLE;
        else                    bit_cnt_d = bit_cnt_q + 5'd1;
      end
      S_RD_TA: if (mdc_fall) begin
        if (bit_cnt_q == 5'd0) begin
          bit_cnt_d = 5'd1;
        end else begin
          oe_d      = 1'b1;
          mdio_d    = 1'b0;
          bit_cnt_d = 5'd0;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: if (mdc_fall) begin
        if (bit_cnt_q == 5'd16) begin
          oe_d    = 1'b0;
          mdio_d  = 1'b0;
          state_d = S_IDLE;
`ifdef SMI_RESP_PREAMBLE_SUPPRESS_EN
          sup_d   = 1'b1;
`endif
        end else begin
          mdio_d    = shift_q[15];
          shift_d   = {shift_q[14:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      S_WR_TA: if (mdc_rise) begin
        shift_d = {shift_q[14:0], bit_in};
        if (bit_cnt_q == 5'd0) begin
          bit_cnt_d = 5'd1;
        end else if ({shift_q[0], bit_in} == 2'b10) begin
          bit_cnt_d = 5'd0;
          state_d   = S_WR_DATA;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR_DATA: if (mdc_rise) begin
        shift_d = {shift_q[14:0], bit_in};
        if (bit_cnt_q == 5'd15) begin
          wdata_d   = {shift_q[14:0], bit_in};
          we_pend_d = 1'b1;
          state_d   = S_IDLE;
`ifdef SMI_RESP_PREAMBLE_SUPPRESS_EN
          sup_d     = 1'b1;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      mdc_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      pre_cnt_q   <= 6'd0;
      bit_cnt_q   <= 5'd0;
      shift_q     <= 16'd0;
      reg_addr_q  <= 5'd0;
      is_rd_q     <= 1'b0;
      match_q     <= 1'b0;
      mdio_q      <= 1'b0;
      oe_q        <= 1'b0;
      rd_q        <= 1'b0;
      rd_dly_q    <= 1'b0;
      we_pend_q   <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= 16'd0;
      err_q       <= 1'b0;
`ifdef SMI_RESP_PREAMBLE_SUPPRESS_EN
      sup_q       <= 1'b0;
`endif
    end else begin
      mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], mdc_i};
      mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
      mdc_prev_q  <= mdc_sync_q[SYNC_STAGES-1];
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      reg_addr_q  <= reg_addr_d;
      is_rd_q     <= is_rd_d;
      match_q     <= match_d;
      mdio_q      <= mdio_d;
      oe_q        <= oe_d;
      rd_q        <= rd_d;
      rd_dly_q    <= rd_q;
      we_pend_q   <= we_pend_d;
      we_q        <= we_pend_q;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
`ifdef SMI_RESP_PREAMBLE_SUPPRESS_EN
      sup_q       <= sup_d;
`endif
    end
  end

  assign mdio_o      = mdio_q;
  assign mdio_oe_o   = oe_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_rd_o    = rd_q;
  assign reg_we_o    = we_q;
  assign reg_wdata_o = wdata_q;
  assign busy_o      = (state_q != S_IDLE);
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_udma_smi_responder.sv
`timescale 1ns/1ps
module tb_udma_smi_responder;

  localparam int         HALF    = 6;
  localparam int         PRE_MIN = 32;
  localparam logic [4:0] PHY     = 5'h03;
  localparam logic [1:0] K_WE = 2'd0, K_RD = 2'd1, K_ERR = 2'd2, K_RDATA = 2'd3;
`ifdef SMI_RESP_PREAMBLE_SUPPRESS_EN
  localparam bit SUP = 1'b1;
`else
  localparam bit SUP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [15:0] data;
  } evt_t;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        mdc = 1'b0;
  logic        mdio_drv = 1'b1;
  logic        mdio_i;
  logic        mdio_o, mdio_oe_o, reg_rd_o, reg_we_o, busy_o, frame_err_o;
  logic [4:0]  reg_addr_o;
  logic [15:0] reg_rdata_i, reg_wdata_o;

  int   checks = 0;
  int   errors = 0;
  int   oe_cycles = 0;
  bit   last_ok = 1'b0;
  logic [15:0] rf [32];
  evt_t exp_q[$];
  evt_t obs_q[$];
  logic [16:0] cap = '0;
  int   ncap = 0;

  udma_smi_responder #(.PREAMBLE_MIN(PRE_MIN), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .phy_addr_i(PHY),
    .mdc_i(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_oe_o(mdio_oe_o),
    .reg_addr_o(reg_addr_o), .reg_rd_o(reg_rd_o), .reg_rdata_i(reg_rdata_i),
    .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o), .busy_o(busy_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Bus with pull-up: the target wins while it drives.
  assign mdio_i = mdio_oe_o ? mdio_o : mdio_drv;

  // Register port: data only valid in the cycle after the strobe.
  always @(posedge clk_i)
    reg_rdata_i <= reg_rd_o ? rf[reg_addr_o] : 16'($urandom);

  // Master-side capture of driven bits (TA bit 2 + 16 data bits).
  always @(posedge mdc) begin
    if (mdio_oe_o) begin
      cap = {cap[15:0], mdio_o};
      ncap++;
      if (ncap == 17) begin
        obs_q.push_back('{K_RDATA, {4'd0, cap[16]}, cap[15:0]});
        ncap = 0;
      end
    end else begin
      ncap = 0;
    end
  end

  task automatic score(input evt_t got);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got=%h required=none", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL scoreboard got=%h required=%h", got, e);
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (mdio_oe_o)   oe_cycles++;
    if (reg_we_o)    score('{K_WE, reg_addr_o, reg_wdata_o});
    if (reg_rd_o)    score('{K_RD, reg_addr_o, 16'h0});
    if (frame_err_o) score('{K_ERR, 5'h0, 16'h0});
    while (obs_q.size() > 0) score(obs_q.pop_front());
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic send_bit(input logic b);
    mdc = 1'b0;
    mdio_drv = b;
    repeat (HALF) @(posedge clk_i);
    #1 mdc = 1'b1;
    repeat (HALF) @(posedge clk_i);
    #1;
  endtask

  // Reference model + master. abort >= 0: reset after that many turnaround/data bits of a read.
  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] ra, input logic [1:0] ta,
                           input logic [15:0] wd, input int abort);
    bit acc, good_op, mine, rd_done;
    int oe_start;
    acc     = (pre >= PRE_MIN) || (SUP && last_ok && pre >= 1);
    good_op = (op == 2'b10) || (op == 2'b01);
    mine    = acc && good_op && (phy == PHY);
    rd_done = 1'b0;
    if (acc) last_ok = 1'b0;
    if (mine) begin
      if (op == 2'b10) begin
        exp_q.push_back('{K_RD, ra, 16'h0});
        if (abort < 0) begin
          exp_q.push_back('{K_RDATA, 5'h0, rf[ra]});
          last_ok = 1'b1;
          rd_done = 1'b1;
        end
      end else if (ta == 2'b10) begin
        exp_q.push_back('{K_WE, ra, wd});
        rf[ra]  = wd;
        last_ok = 1'b1;
      end else begin
        exp_q.push_back('{K_ERR, 5'h0, 16'h0});
      end
    end
    oe_start = oe_cycles;
    repeat (pre) send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1);
    send_bit(op[1]); send_bit(op[0]);
    if (good_op) begin
      for (int i = 4; i >= 0; i--) send_bit(phy[i]);
      for (int i = 4; i >= 0; i--) send_bit(ra[i]);
      if (op == 2'b10) begin
        repeat ((abort < 0) ? 18 : abort) send_bit(1'b1);
        if (abort >= 0 && mine) begin
          check("pre_abort_oe", 32'(mdio_oe_o), 32'd1);
          @(posedge clk_i); #1 rstn_i = 1'b0;
          @(posedge clk_i); #1;
          check("abort_oe", 32'(mdio_oe_o), 32'd0);
          check("abort_busy", 32'(busy_o), 32'd0);
          rstn_i  = 1'b1;
          last_ok = 1'b0;
          return;
        end
      end else begin
        send_bit(ta[1]); send_bit(ta[0]);
        if (ta == 2'b10 || phy != PHY)
          for (int i = 15; i >= 0; i--) send_bit(wd[i]);
      end
    end
    if (rd_done) begin
      send_bit(1'b1);
      check("read_release_oe", 32'(mdio_oe_o), 32'd0);
    end else begin
      check("no_drive", 32'(oe_cycles - oe_start), 32'd0);
    end
    check("frame_end_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [1:0] op, ta;
    logic [4:0] phy;
    int r;
    for (int i = 0; i < 32; i++) rf[i] = 16'($urandom);
    repeat (4) @(posedge clk_i);
    #1;
    check("rst_mdio", 32'(mdio_o), 32'd0);
    check("rst_oe", 32'(mdio_oe_o), 32'd0);
    check("rst_strobes", {29'd0, reg_rd_o, reg_we_o, frame_err_o}, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_regs", {11'd0, reg_addr_o, reg_wdata_o}, 32'd0);
    rstn_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;

    run_frame(32, 2'b01, PHY, 5'h0A, 2'b10, 16'hBEEF, -1);
    rf[5'h11] = 16'h1234;
    run_frame(32, 2'b10, PHY, 5'h11, 2'b00, 16'h0000, -1);
    run_frame(32, 2'b10, 5'h04, 5'h11, 2'b00, 16'h0000, -1);
    run_frame(32, 2'b01, PHY, 5'h05, 2'b10, 16'h5A3C, -1);
    run_frame(32, 2'b01, PHY, 5'h07, 2'b11, 16'h0000, -1);
    run_frame(31, 2'b01, PHY, 5'h08, 2'b10, 16'hCAFE, -1);
    run_frame(32, 2'b01, PHY, 5'h08, 2'b10, 16'hCAFE, -1);
    run_frame(32, 2'b10, PHY, 5'h0C, 2'b00, 16'h0000, 8);
    run_frame(32, 2'b01, PHY, 5'h0C, 2'b10, 16'h8001, -1);
    run_frame(32, 2'b10, PHY, 5'h0C, 2'b00, 16'h0000, -1);
    run_frame(32, 2'b01, PHY, 5'h12, 2'b10, 16'h7E81, -1);
    run_frame(1,  2'b10, PHY, 5'h12, 2'b00, 16'h0000, -1);

    for (int n = 0; n < 16; n++) begin
      r   = int'($urandom_range(0, 19));
      op  = (r < 9) ? 2'b10 : (r < 18) ? 2'b01 : (r == 18) ? 2'b00 : 2'b11;
      phy = ($urandom_range(0, 3) != 0) ? PHY : 5'(5'h04 + $urandom_range(0, 27));
      ta  = ($urandom_range(0, 6) != 0) ? 2'b10 : 2'(3 - $urandom_range(0, 2) * 2 + 0);
      if (ta == 2'b10 && phy == PHY && op == 2'b01 && $urandom_range(0, 5) == 0) ta = 2'b00;
      run_frame(32 + int'($urandom_range(0, 3)), op, phy, 5'($urandom), ta, 16'($urandom), -1);
    end

    repeat (4) send_bit(1'b1);
    repeat (10) @(posedge clk_i);
    check("leftover_events", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
